// File: rtl/rvfi_trace_fifo_if.sv
// rvfi_trace_fifo_if: RVFI retirement input, trace stream output and status bundle.
interface rvfi_trace_fifo_if #(parameter int DEPTH = 8, parameter int DROP_W = 16);
  logic                     rvfi_valid;
  logic [63:0]              rvfi_order;
  logic [31:0]              rvfi_insn;
  logic                     rvfi_trap;
  logic [31:0]              rvfi_pc_rdata;
  logic [31:0]              rvfi_pc_wdata;
  logic [4:0]               rvfi_rd_addr;
  logic [31:0]              rvfi_rd_wdata;
  logic                     trace_valid;
  logic                     trace_ready;
  logic [63:0]              trace_order;
  logic [31:0]              trace_insn;
  logic                     trace_trap;
  logic [31:0]              trace_pc_rdata;
  logic [31:0]              trace_pc_wdata;
  logic [4:0]               trace_rd_addr;
  logic [31:0]              trace_rd_wdata;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic [DROP_W-1:0]        drop_count;
  logic                     order_err;
  logic                     clear;
  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rd_addr, rvfi_rd_wdata, trace_ready, clear,
    input  trace_valid, trace_order, trace_insn, trace_trap, trace_pc_rdata, trace_pc_wdata,
           trace_rd_addr, trace_rd_wdata, level, overflow, drop_count, order_err
  );
  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rd_addr, rvfi_rd_wdata, trace_ready, clear,
    output trace_valid, trace_order, trace_insn, trace_trap, trace_pc_rdata, trace_pc_wdata,
           trace_rd_addr, trace_rd_wdata, level, overflow, drop_count, order_err
  );
endinterface

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: buffers RVFI retirements as trace records, flags drops and order breaks.
module rvfi_trace_fifo #(parameter int DEPTH = 8, parameter int DROP_W = 16) (
  input  logic              clk,
  input  logic              rst,
  rvfi_trace_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 198;
  logic [RW-1:0]     r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic              r_overflow, r_order_err, r_expect_vld;
  logic [DROP_W-1:0] r_drop_count;
  logic [63:0]       r_expect;
  logic              w_full, w_empty, w_pop, w_push, w_drop, w_order_bad;
  logic [RW-1:0]     w_rec, w_head;
  logic [DROP_W-1:0] w_drop_inc;
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty     = r_wr_ptr == r_rd_ptr;
  assign w_pop       = !w_empty && bus.trace_ready;
  assign w_push      = bus.rvfi_valid && (!w_full || w_pop);
  assign w_drop      = bus.rvfi_valid && w_full && !w_pop;
  assign w_order_bad = bus.rvfi_valid && r_expect_vld && (bus.rvfi_order != r_expect);
  assign w_drop_inc  = &r_drop_count ? r_drop_count : r_drop_count + DROP_W'(1);
  assign w_rec = {bus.rvfi_order, bus.rvfi_insn, bus.rvfi_trap, bus.rvfi_pc_rdata,
                  bus.rvfi_pc_wdata, bus.rvfi_rd_addr, bus.rvfi_rd_wdata};
  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  assign {bus.trace_order, bus.trace_insn, bus.trace_trap, bus.trace_pc_rdata,
          bus.trace_pc_wdata, bus.trace_rd_addr, bus.trace_rd_wdata} = w_head;
  assign bus.trace_valid = !w_empty;
  assign bus.level       = r_wr_ptr - r_rd_ptr;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_count;
  assign bus.order_err   = r_order_err;
  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_order_err  <= 1'b0;
      r_expect     <= '0;
      r_expect_vld <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow   <= w_drop || (r_overflow && !bus.clear);
      r_order_err  <= w_order_bad || (r_order_err && !bus.clear);
      r_drop_count <= w_drop ? (bus.clear ? DROP_W'(1) : w_drop_inc) : (bus.clear ? '0 : r_drop_count);
      if (bus.rvfi_valid) begin
        r_expect     <= bus.rvfi_order + 64'd1;
        r_expect_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// tb_rvfi_trace_fifo: directed and randomized-stall checks of rvfi_trace_fifo.
module tb_rvfi_trace_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  rvfi_trace_fifo_if bus ();
  rvfi_trace_fifo dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic retire(input logic [63:0] ord);
    bus.rvfi_valid    = 1'b1;
    bus.rvfi_order    = ord;
    bus.rvfi_insn     = 32'h13 + (ord[31:0] << 2);
    bus.rvfi_trap     = ord[0];
    bus.rvfi_pc_rdata = 32'h8000_0000 + (ord[31:0] << 2);
    bus.rvfi_pc_wdata = 32'h8000_0004 + (ord[31:0] << 2);
    bus.rvfi_rd_addr  = ord[4:0];
    bus.rvfi_rd_wdata = ~ord[31:0];
  endtask
  function automatic logic [197:0] head;
    return {bus.trace_order, bus.trace_insn, bus.trace_trap, bus.trace_pc_rdata,
            bus.trace_pc_wdata, bus.trace_rd_addr, bus.trace_rd_wdata};
  endfunction
  logic [197:0] q[$];
  logic [197:0] got, exp, held;
  logic stalled, pop, was_full;
  int n;
  logic [63:0] ord;
  initial begin
    bus.rvfi_valid = 0; bus.rvfi_order = 0; bus.rvfi_insn = 0; bus.rvfi_trap = 0;
    bus.rvfi_pc_rdata = 0; bus.rvfi_pc_wdata = 0; bus.rvfi_rd_addr = 0; bus.rvfi_rd_wdata = 0;
    bus.trace_ready = 0; bus.clear = 0;
    repeat (2) step;
    chk("rst_valid", bus.trace_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop", bus.drop_count, 0);
    chk("rst_order_err", bus.order_err, 0);
    chk("rst_order", bus.trace_order, 0);
    chk("rst_insn", bus.trace_insn, 0);
    rst = 1;
    step;
    // single record: no bypass, visible one cycle later, then popped
    retire(0);
    bus.trace_ready = 1;
    chk("t1_nobypass", bus.trace_valid, 0);
    step;
    bus.rvfi_valid = 0;
    chk("t1_valid", bus.trace_valid, 1);
    chk("t1_order", bus.trace_order, 0);
    chk("t1_insn", bus.trace_insn, 32'h13);
    chk("t1_level1", bus.level, 1);
    step;
    chk("t1_level0", bus.level, 0);
    chk("t1_empty", bus.trace_valid, 0);
    // overflow: 10 retires into 8 entries
    bus.trace_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      retire(64'(i));
      step;
    end
    bus.rvfi_valid = 0;
    chk("t2_level", bus.level, 8);
    chk("t2_overflow", bus.overflow, 1);
    chk("t2_drop", bus.drop_count, 2);
    bus.trace_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", bus.trace_order, 64'(i));
      step;
    end
    chk("t2_level0", bus.level, 0);
    chk("t2_order_err", bus.order_err, 0);
    bus.clear = 1;
    step;
    bus.clear = 0;
    chk("t2_clr_ovf", bus.overflow, 0);
    chk("t2_clr_drop", bus.drop_count, 0);
    // full with simultaneous push and pop
    bus.trace_ready = 0;
    for (int i = 11; i <= 18; i++) begin
      retire(64'(i));
      step;
    end
    retire(19);
    bus.trace_ready = 1;
    step;
    bus.rvfi_valid = 0;
    bus.trace_ready = 0;
    chk("t3_level", bus.level, 8);
    chk("t3_overflow", bus.overflow, 0);
    chk("t3_drop", bus.drop_count, 0);
    chk("t3_head", bus.trace_order, 12);
    bus.trace_ready = 1;
    for (int i = 12; i <= 19; i++) begin
      chk("t3_drain", bus.trace_order, 64'(i));
      step;
    end
    chk("t3_level0", bus.level, 0);
    // order breaks and clear interaction (expectation is 20 here)
    retire(5);
    step;
    bus.rvfi_valid = 0;
    chk("t4_err_a", bus.order_err, 1);
    bus.clear = 1;
    step;
    bus.clear = 0;
    chk("t4_clr_a", bus.order_err, 0);
    retire(7);
    step;
    bus.rvfi_valid = 0;
    chk("t4_err_b", bus.order_err, 1);
    bus.clear = 1;
    step;
    bus.clear = 0;
    chk("t4_clr_b", bus.order_err, 0);
    retire(8);
    step;
    bus.rvfi_valid = 0;
    chk("t4_ok", bus.order_err, 0);
    retire(20);
    bus.clear = 1;
    step;
    bus.rvfi_valid = 0;
    chk("t4_set_wins", bus.order_err, 1);
    step;
    bus.clear = 0;
    chk("t4_clr_c", bus.order_err, 0);
    repeat (4) step;
    chk("t4_level0", bus.level, 0);
    // random stalls against a queue model
    ord = 21;
    n = 0;
    stalled = 0;
    held = '0;
    while (n < 1000) begin
      bus.rvfi_valid = $urandom_range(0, 3) != 0;
      bus.trace_ready = $urandom_range(0, 1) != 0;
      if (bus.rvfi_valid) begin
        bus.rvfi_order = ord;
        bus.rvfi_insn = $urandom;
        bus.rvfi_trap = 1'($urandom);
        bus.rvfi_pc_rdata = $urandom;
        bus.rvfi_pc_wdata = $urandom;
        bus.rvfi_rd_addr = 5'($urandom);
        bus.rvfi_rd_wdata = $urandom;
      end
      got = head();
      chk("t5_level", bus.level, 64'(q.size()));
      chk("t5_valid", bus.trace_valid, q.size() != 0);
      if (stalled) begin
        chk("t5_hold_hi", got[197:134], held[197:134]);
        chk("t5_hold_lo", got[133:70], held[133:70]);
        chk("t5_hold_lo2", 64'(got[69:0]), 64'(held[69:0]));
      end
      was_full = q.size() == 8;
      pop = q.size() != 0 && bus.trace_ready;
      stalled = q.size() != 0 && !bus.trace_ready;
      held = got;
      if (pop) begin
        exp = q.pop_front();
        chk("t5_ord", got[197:134], exp[197:134]);
        chk("t5_mid", got[133:70], exp[133:70]);
        chk("t5_low", 64'(got[69:0]), 64'(exp[69:0]));
      end
      if (bus.rvfi_valid) begin
        if (!was_full || pop)
          q.push_back({bus.rvfi_order, bus.rvfi_insn, bus.rvfi_trap, bus.rvfi_pc_rdata,
                       bus.rvfi_pc_wdata, bus.rvfi_rd_addr, bus.rvfi_rd_wdata});
        ord++;
        n++;
      end
      step;
    end
    bus.rvfi_valid = 0;
    bus.trace_ready = 1;
    while (q.size() != 0) begin
      got = head();
      exp = q.pop_front();
      chk("t5_tail", got[197:134], exp[197:134]);
      step;
    end
    chk("t5_level0", bus.level, 0);
    chk("t5_order_err", bus.order_err, 0);
    // asynchronous reset with 5 entries held
    bus.trace_ready = 0;
    for (int i = 100; i < 105; i++) begin
      retire(64'(i));
      step;
    end
    bus.rvfi_valid = 0;
    chk("t6_level5", bus.level, 5);
    #2;
    rst = 0;
    #1;
    chk("t6_async_level", bus.level, 0);
    chk("t6_async_valid", bus.trace_valid, 0);
    step;
    rst = 1;
    retire(7777);
    step;
    bus.rvfi_valid = 0;
    chk("t6_first_ok", bus.order_err, 0);
    chk("t6_head", bus.trace_order, 7777);
    chk("t6_level1", bus.level, 1);
    chk("t6_ovf", bus.overflow, 0);
    retire(7778);
    step;
    bus.rvfi_valid = 0;
    chk("t6_second_ok", bus.order_err, 0);
    chk("t6_level2", bus.level, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
